vertex_transform_pipe: RTL

Parametrised successor to the single-stream geometry engine. Accepts Q16.16 object-space vertices over a valid/ready stream and applies a double-buffered, host-loaded 4x4 MVP matrix. Computes the perspective divide with one shared reciprocal unit, maps to a parametrised viewport, and emits screen-space vertices plus pass-through attributes over a valid/ready stream into the raster vertex FIFO.

---
 rtl/vtp_pkg.sv | 35 +++
 rtl/vtp_recip.sv | 63 ++++++
 rtl/vertex_transform_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vtp_pkg.sv
// Shared types, constants and the Q16.16 multiply for the vertex transform pipe.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vtp_pkg;

  localparam logic [31:0] ONE_Q16   = 32'h0001_0000;
  localparam logic [31:0] SAT_RECIP = 32'h7FFF_FFFF;

  // 4x4 matrix, element index = row*4 + col
  typedef logic [15:0][31:0] mat_t;

  // Listed from element 15 down to element 0; the diagonal pattern is symmetric.
  localparam mat_t IDENTITY = {ONE_Q16, 32'h0, 32'h0, 32'h0,
                               32'h0, ONE_Q16, 32'h0, 32'h0,
                               32'h0, 32'h0, ONE_Q16, 32'h0,
                               32'h0, 32'h0, 32'h0, ONE_Q16};

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFORM,
    S_RECIP,
    S_NDC,
    S_VIEWPORT,
    S_OUT
  } vtp_state_t;

  // Q16.16 product: full 64-bit signed product, arithmetic shift, keep low 32 bits
  function automatic logic signed [31:0] mul_q16(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 16);
  endfunction

endpackage

// File: rtl/vtp_recip.sv
// Signed Q16.16 reciprocal r = sign(w)*min(floor(2^32/|w|), 0x7FFFFFFF) by restoring division.
// Latency: result valid and o_done consumed 34 cycles after the i_start edge.
// Backpressure: none; o_done is a single-cycle strobe, caller must take the result then.
module vtp_recip
  import vtp_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic signed [31:0] i_w,
  output logic               o_done,
  output logic signed [31:0] o_r
);

  logic        busy;
  logic [5:0]  cnt;
  logic        neg;
  logic [31:0] div;
  logic [31:0] rem;
  logic [32:0] quo;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] mag;

  // One quotient bit per cycle; dividend is 2^32 so only the first shifted-in bit is 1.
  // A zero divisor yields an all-ones quotient, which the saturation below catches.
  always_comb begin
    rem_sh = {rem, (cnt == 6'd0)};
    ge     = (rem_sh >= {1'b0, div});
    mag    = (quo > 33'h0_7FFF_FFFF) ? SAT_RECIP : quo[31:0];
    o_done = busy && (cnt == 6'd33);
  end

  // Load on start, iterate 33 times, then apply saturation and sign in the final cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      neg  <= 1'b0;
      div  <= '0;
      rem  <= '0;
      quo  <= '0;
      o_r  <= '0;
    end else if (i_start) begin
      busy <= 1'b1;
      cnt  <= '0;
      neg  <= i_w[31];
      div  <= i_w[31] ? -i_w : i_w;
      rem  <= '0;
      quo  <= '0;
    end else if (busy) begin
      if (cnt == 6'd33) begin
        busy <= 1'b0;
        o_r  <= neg ? -mag : mag;
      end else begin
        rem <= 32'(ge ? (rem_sh - {1'b0, div}) : rem_sh);
        quo <= {quo[31:0], ge};
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/vertex_transform_pipe.sv
// MVP transform, perspective divide and viewport map of Q16.16 vertices (optional macro VTP_NEAR_CLIP_EN).
// Latency: o_out_valid visible in the 41st cycle after the accept edge; one vertex per 42 cycles.
// Backpressure: result held in S_OUT until i_out_ready; no new vertex accepted until handshake.
module vertex_transform_pipe
  import vtp_pkg::*;
#(
  parameter int          SCREEN_W = 320,
  parameter int          SCREEN_H = 240,
  parameter int          Z_BITS   = 8,
  parameter int          ATTR_N   = 2,
  parameter int          ATTR_W   = 32,
  parameter logic [31:0] NEAR_Q16 = 32'h0000_1999
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vtx_valid,
  output logic                     o_vtx_ready,
  input  logic [31:0]              i_x,
  input  logic [31:0]              i_y,
  input  logic [31:0]              i_z,
  input  logic [ATTR_N*ATTR_W-1:0] i_attr,
  input  logic                     i_mat_we,
  input  logic [3:0]               i_mat_addr,
  input  logic [31:0]              i_mat_wdata,
  input  logic                     i_mat_swap,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [31:0]              o_x,
  output logic [31:0]              o_y,
  output logic [Z_BITS-1:0]        o_z,
  output logic [ATTR_N*ATTR_W-1:0] o_attr,
  output logic                     o_clipped,
  output logic                     o_busy,
  output logic [15:0]              o_vtx_count
);

  localparam logic signed [31:0] HALF_W  = 32'(SCREEN_W * 32768);
  localparam logic signed [31:0] HALF_H  = 32'(SCREEN_H * 32768);
  localparam logic signed [31:0] HALF_Z  = 32'(((1 << Z_BITS) - 1) * 32768);
  localparam logic [63:0]        Z_LIMIT = 64'd1 << (16 + Z_BITS);

  vtp_state_t               state, state_nx;
  logic [1:0]               row;
  logic signed [31:0]       vx, vy, vz;
  logic [ATTR_N*ATTR_W-1:0] attr_q;
  logic [3:0][31:0]         clip_q;
  logic signed [31:0]       ndc_x, ndc_y, ndc_z;
  mat_t                     shadow, shadow_nx, active;
  logic                     swap_pend, do_copy;
  logic                     recip_start, recip_done;
  logic signed [31:0]       recip_r;
  logic signed [31:0]       row_sum;
  logic signed [31:0]       vp_x, vp_y, zs;
  logic [Z_BITS-1:0]        z_cl;
  logic                     clip_flag;

  vtp_recip u_recip (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (recip_start),
    .i_w     (row_sum),
    .o_done  (recip_done),
    .o_r     (recip_r)
  );

  assign o_busy = (state != S_IDLE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs; a pending swap steals one idle cycle for the bank copy
  always_comb begin
    state_nx    = state;
    o_vtx_ready = 1'b0;
    o_out_valid = 1'b0;
    recip_start = 1'b0;
    do_copy     = 1'b0;
    case (state)
      S_IDLE: begin
        if (swap_pend) begin
          do_copy = 1'b1;
        end else begin
          o_vtx_ready = !i_rst;
          if (i_vtx_valid && !i_rst) state_nx = S_XFORM;
        end
      end
      S_XFORM: begin
        if (row == 2'd3) begin
          recip_start = 1'b1;
          state_nx    = S_RECIP;
        end
      end
      S_RECIP:    if (recip_done) state_nx = S_NDC;
      S_NDC:      state_nx = S_VIEWPORT;
      S_VIEWPORT: state_nx = S_OUT;
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_nx = S_IDLE;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  // One matrix row dot product per cycle; the w row feeds the reciprocal directly
  always_comb begin
    row_sum = mul_q16($signed(active[{row, 2'd0}]), vx)
            + mul_q16($signed(active[{row, 2'd1}]), vy)
            + mul_q16($signed(active[{row, 2'd2}]), vz)
            + $signed(active[{row, 2'd3}]);
  end

  // Host write merged into the shadow bank so a same-cycle copy picks it up
  always_comb begin
    shadow_nx = shadow;
    if (i_mat_we) shadow_nx[i_mat_addr] = i_mat_wdata;
  end

  // Viewport scale and depth clamp
  always_comb begin
    vp_x = mul_q16(ndc_x + $signed(ONE_Q16), HALF_W);
    vp_y = mul_q16(ndc_y + $signed(ONE_Q16), HALF_H);
    zs   = mul_q16(ndc_z + $signed(ONE_Q16), HALF_Z);
    if (zs < 0)                    z_cl = '0;
    else if (64'(zs) >= Z_LIMIT)   z_cl = '1;
    else                           z_cl = zs[16+Z_BITS-1:16];
  end

`ifdef VTP_NEAR_CLIP_EN
  assign clip_flag = $signed(clip_q[3]) < $signed(NEAR_Q16);
`else
  assign clip_flag = 1'b0;
  logic unused_near;
  assign unused_near = ^{NEAR_Q16, clip_q[3]};
`endif

  // Matrix banks, vertex latch and datapath stages
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow      <= IDENTITY;
      active      <= IDENTITY;
      swap_pend   <= 1'b0;
      row         <= '0;
      vx          <= '0;
      vy          <= '0;
      vz          <= '0;
      attr_q      <= '0;
      clip_q      <= '0;
      ndc_x       <= '0;
      ndc_y       <= '0;
      ndc_z       <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_z         <= '0;
      o_attr      <= '0;
      o_clipped   <= 1'b0;
      o_vtx_count <= '0;
    end else begin
      shadow    <= shadow_nx;
      swap_pend <= i_mat_swap | (swap_pend & ~do_copy);
      if (do_copy) active <= shadow_nx;
      if (o_vtx_ready && i_vtx_valid) begin
        vx     <= i_x;
        vy     <= i_y;
        vz     <= i_z;
        attr_q <= i_attr;
      end
      if (state == S_XFORM) begin
        clip_q[row] <= row_sum;
        row         <= row + 2'd1;
      end
      if (state == S_NDC) begin
        ndc_x <= mul_q16($signed(clip_q[0]), recip_r);
        ndc_y <= mul_q16($signed(clip_q[1]), recip_r);
        ndc_z <= mul_q16($signed(clip_q[2]), recip_r);
      end
      if (state == S_VIEWPORT) begin
        o_x       <= vp_x;
        o_y       <= vp_y;
        o_z       <= z_cl;
        o_attr    <= attr_q;
        o_clipped <= clip_flag;
      end
      if (o_out_valid && i_out_ready) o_vtx_count <= o_vtx_count + 16'd1;
    end
  end

endmodule
